dbg_snapshot_unit: RTL and testbench

Parametrised debug controller between the UART pair (uart_rx/uart_tx) and the pipeline under test. It decodes single-byte commands, controls the pipeline through a clock enable and a reset, supports run-to-breakpoint and single-step modes, and serialises a SNAP_W-bit state snapshot as a framed byte stream. It succeeds debug_unit: width-generic snapshot, breakpoint compare, halt/continue and frame header.

---
 rtl/dbg_snapshot_unit.sv | 221 ++++++++++++++++++++++
 tb/tb_dbg_snapshot_unit.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_snapshot_unit.sv
// rtl/dbg_snapshot_unit.sv - UART-driven debug controller with breakpoint, single-step and framed snapshot dump
//
// Decodes single-byte commands from the UART receiver and steers the pipeline
// under test through a clock enable and a reset. A dump latches SNAP_W bits of
// pipeline state into a shadow register and streams it out as a frame:
// header 0xA5, then payload bytes (bit 0 of snap_data goes out first).
//
// Build option: DBG_CHECKSUM_EN appends one byte equal to the XOR of the
// header and every payload byte.
//
// Commands (IDLE only): 'r' pipeline reset, 's' single step + dump,
// 'c' continue, 'd' dump, 'b' <pc> set breakpoint, 'n' clear breakpoint.
// 'h' halts a running pipeline and dumps.
//
// Ports:
//   top_clk       in   clock, rising edge
//   rst           in   asynchronous active-low reset
//   rx_done_tick  in   one-cycle strobe, rx_bus valid
//   rx_bus        in   received byte
//   tx_done_tick  in   one-cycle strobe, transmitter finished the byte
//   snap_data     in   pipeline state to dump
//   pc            in   current pipeline pc
//   pipe_en       out  pipeline clock enable
//   rst_pipe      out  pipeline reset, active-high
//   tx_start      out  one-cycle transmit request
//   tx_bus        out  byte to transmit
//   busy          out  high outside IDLE

module dbg_snapshot_unit #(
  parameter int SNAP_W  = 1376,
  parameter int PC_W    = 8,
  parameter int RST_CYC = 4
) (
  input  logic              top_clk,
  input  logic              rst,
  input  logic              rx_done_tick,
  input  logic [7:0]        rx_bus,
  input  logic              tx_done_tick,
  input  logic [SNAP_W-1:0] snap_data,
  input  logic [PC_W-1:0]   pc,
  output logic              pipe_en,
  output logic              rst_pipe,
  output logic              tx_start,
  output logic [7:0]        tx_bus,
  output logic              busy
);

  localparam int NBYTES   = (SNAP_W + 7) / 8;
  localparam int SHADOW_W = NBYTES * 8;
`ifdef DBG_CHECKSUM_EN
  localparam int FRAME_LEN = NBYTES + 2;
`else
  localparam int FRAME_LEN = NBYTES + 1;
`endif
  localparam int IDX_W = $clog2(FRAME_LEN + 1);
  localparam int CNT_W = $clog2(RST_CYC + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYC - 1);

  localparam logic [7:0] HEADER   = 8'hA5;
  localparam logic [7:0] CMD_RST  = 8'h72;
  localparam logic [7:0] CMD_STEP = 8'h73;
  localparam logic [7:0] CMD_CONT = 8'h63;
  localparam logic [7:0] CMD_DUMP = 8'h64;
  localparam logic [7:0] CMD_BP   = 8'h62;
  localparam logic [7:0] CMD_NOBP = 8'h6E;
  localparam logic [7:0] CMD_HALT = 8'h68;

  typedef enum logic [2:0] {
    PRST, IDLE, BP_ARG, STEP, RUN, CAPTURE, SEND, WAIT_TX
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      rst_cnt_q;
  logic [PC_W-1:0]       bp_q;
  logic                  bp_valid_q;
  logic                  run_first_q;
  logic [SHADOW_W-1:0]   shadow_q;
  logic [IDX_W-1:0]      idx_q;
  logic [7:0]            tx_bus_q;
  logic                  load_pend_q;
`ifdef DBG_CHECKSUM_EN
  logic [7:0]            csum_q;
`endif

  logic bp_hit;
  logic halt_rx;

  assign bp_hit  = bp_valid_q && (pc == bp_q);
  assign halt_rx = rx_done_tick && (rx_bus == CMD_HALT);

  assign rst_pipe = (state_q == PRST);
  assign busy     = (state_q != IDLE);
  assign tx_bus   = tx_bus_q;

  always_ff @(posedge top_clk or negedge rst) begin
    if (!rst) begin
      state_q <= PRST;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pipe_en  = 1'b0;
    tx_start = 1'b0;
    case (state_q)
      PRST: begin
        if (rst_cnt_q == RST_LAST) state_d = IDLE;
      end
      IDLE: begin
        if (rx_done_tick) begin
          case (rx_bus)
            CMD_RST:  state_d = PRST;
            CMD_STEP: state_d = STEP;
            CMD_CONT: state_d = RUN;
            CMD_DUMP: state_d = CAPTURE;
            CMD_BP:   state_d = BP_ARG;
            default:  state_d = IDLE;
          endcase
        end
      end
      BP_ARG: begin
        if (rx_done_tick) state_d = IDLE;
      end
      STEP: begin
        pipe_en = 1'b1;
        state_d = CAPTURE;
      end
      RUN: begin
        // The compare is masked on the first cycle so a 'c' issued while
        // parked on the breakpoint moves the pipeline off it.
        pipe_en = !halt_rx && (run_first_q || !bp_hit);
        if (halt_rx || (!run_first_q && bp_hit)) state_d = CAPTURE;
      end
      CAPTURE: begin
        state_d = SEND;
      end
      SEND: begin
        tx_start = 1'b1;
        state_d  = WAIT_TX;
      end
      WAIT_TX: begin
        if (load_pend_q) begin
          state_d = SEND;
        end else if (tx_done_tick && (idx_q == LAST_IDX)) begin
          state_d = IDLE;
        end
      end
      default: state_d = PRST;
    endcase
  end

  always_ff @(posedge top_clk or negedge rst) begin
    if (!rst) begin
      rst_cnt_q   <= '0;
      bp_q        <= '0;
      bp_valid_q  <= 1'b0;
      run_first_q <= 1'b0;
      shadow_q    <= '0;
      idx_q       <= '0;
      tx_bus_q    <= '0;
      load_pend_q <= 1'b0;
`ifdef DBG_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      rst_cnt_q   <= ((state_q == PRST) && (rst_cnt_q != RST_LAST)) ?
                     rst_cnt_q + CNT_W'(1) : '0;
      run_first_q <= (state_d == RUN) && (state_q != RUN);

      case (state_q)
        IDLE: begin
          if (rx_done_tick && (rx_bus == CMD_NOBP)) bp_valid_q <= 1'b0;
        end
        BP_ARG: begin
          if (rx_done_tick) begin
            bp_q       <= rx_bus[PC_W-1:0];
            bp_valid_q <= 1'b1;
          end
        end
        CAPTURE: begin
          shadow_q    <= SHADOW_W'(snap_data);
          idx_q       <= '0;
          tx_bus_q    <= HEADER;
          load_pend_q <= 1'b0;
`ifdef DBG_CHECKSUM_EN
          csum_q      <= HEADER;
`endif
        end
        WAIT_TX: begin
          // A finished byte first raises load_pend; the next byte is loaded
          // one cycle later, so tx_bus only changes on the way into SEND.
          if (load_pend_q) begin
            load_pend_q <= 1'b0;
            idx_q       <= idx_q + IDX_W'(1);
`ifdef DBG_CHECKSUM_EN
            if (idx_q < IDX_W'(NBYTES)) begin
              tx_bus_q <= shadow_q[7:0];
              shadow_q <= shadow_q >> 8;
              csum_q   <= csum_q ^ shadow_q[7:0];
            end else begin
              tx_bus_q <= csum_q;
            end
`else
            tx_bus_q <= shadow_q[7:0];
            shadow_q <= shadow_q >> 8;
`endif
          end else if (tx_done_tick && (idx_q != LAST_IDX)) begin
            load_pend_q <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_snapshot_unit.sv
// tb/tb_dbg_snapshot_unit.sv - self-checking bench for dbg_snapshot_unit

module tb_dbg_snapshot_unit;

  localparam int SNAP_W  = 20;
  localparam int PC_W    = 8;
  localparam int RST_CYC = 4;
  localparam int NB      = (SNAP_W + 7) / 8;
`ifdef DBG_CHECKSUM_EN
  localparam int FL = NB + 2;
`else
  localparam int FL = NB + 1;
`endif

  logic              top_clk = 1'b0;
  logic              rst = 1'b1;
  logic              rx_done_tick = 1'b0;
  logic [7:0]        rx_bus = 8'h00;
  logic              tx_done_tick = 1'b0;
  logic [SNAP_W-1:0] snap_data = '0;
  logic [PC_W-1:0]   pc_r = '0;
  logic              pipe_en, rst_pipe, tx_start, busy;
  logic [7:0]        tx_bus;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int en_cnt = 0;
  int n_start = 0;
  int done_cyc = 0;
  logic holding = 1'b0;
  logic frame_started = 1'b0;
  logic [7:0] held = 8'h00;
  logic [7:0] exp_q[$];
  logic [7:0] log_q[$];

  dbg_snapshot_unit #(.SNAP_W(SNAP_W), .PC_W(PC_W), .RST_CYC(RST_CYC)) dut (
    .top_clk(top_clk), .rst(rst), .rx_done_tick(rx_done_tick), .rx_bus(rx_bus),
    .tx_done_tick(tx_done_tick), .snap_data(snap_data), .pc(pc_r),
    .pipe_en(pipe_en), .rst_pipe(rst_pipe), .tx_start(tx_start),
    .tx_bus(tx_bus), .busy(busy)
  );

  always #5 top_clk = ~top_clk;

  // Pipeline stand-in: pc counts enabled edges, cleared by rst_pipe.
  always @(posedge top_clk) begin
    cyc <= cyc + 1;
    if (rst_pipe) pc_r <= '0;
    else if (pipe_en) pc_r <= pc_r + 1'b1;
    if (pipe_en && !rst_pipe) en_cnt <= en_cnt + 1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected frame: header, little-endian bytes of the zero-extended snapshot,
  // optional XOR checksum.
  task automatic push_frame(input logic [SNAP_W-1:0] s);
    logic [NB*8-1:0] p;
    logic [7:0] b;
`ifdef DBG_CHECKSUM_EN
    logic [7:0] x;
    x = 8'hA5;
`endif
    p = (NB*8)'(s);
    exp_q.push_back(8'hA5);
    for (int k = 0; k < NB; k++) begin
      b = p[8*k +: 8];
      exp_q.push_back(b);
`ifdef DBG_CHECKSUM_EN
      x = x ^ b;
`endif
    end
`ifdef DBG_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  // Frame checker: every tx_start must carry the next expected byte, come two
  // cycles after the previous acknowledge, and tx_bus must hold until acked.
  always @(negedge top_clk) begin
    if (!rst) begin
      holding = 1'b0;
      frame_started = 1'b0;
    end else begin
      if (holding) chk("tx_hold", tx_bus, held);
      if (!busy) begin
        chk("idle_txs", tx_start, 1'b0);
        chk("idle_en", pipe_en, 1'b0);
        frame_started = 1'b0;
      end
      if (rst_pipe) chk("prst_en", pipe_en, 1'b0);
      if (tx_start) begin
        chk("txs_while_hold", holding, 1'b0);
        if (exp_q.size() == 0) chk("unexpected_txs", tx_bus, 64'hFFFF);
        else chk("tx_byte", tx_bus, exp_q.pop_front());
        if (frame_started) chk("tx_gap", cyc - done_cyc, 2);
        log_q.push_back(tx_bus);
        frame_started = 1'b1;
        holding = 1'b1;
        held = tx_bus;
        n_start++;
      end
      if (tx_done_tick && holding) begin
        holding = 1'b0;
        done_cyc = cyc;
      end
    end
  end

  // UART transmitter stand-in: acknowledge each byte three cycles later.
  initial begin
    forever begin
      @(negedge top_clk);
      if (tx_start) begin
        repeat (3) @(posedge top_clk);
        #1 tx_done_tick = 1'b1;
        @(posedge top_clk);
        #1 tx_done_tick = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge top_clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    rx_bus = b;
    rx_done_tick = 1'b1;
    step();
    rx_done_tick = 1'b0;
    rx_bus = 8'h00;
  endtask

  task automatic send_cmd_en(input logic [7:0] b, input logic exp_en, input string nm);
    rx_bus = b;
    rx_done_tick = 1'b1;
    #1;
    chk(nm, pipe_en, exp_en);
    @(posedge top_clk);
    #1;
    rx_done_tick = 1'b0;
    rx_bus = 8'h00;
  endtask

  task automatic wait_idle(input int max, input string nm);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < max) begin
      step();
      n++;
    end
    chk(nm, busy, 1'b0);
  endtask

  initial begin
    int n;
    int e0;
    int s0;
    int l0;

    // Asynchronous reset, before any clock edge.
    #2 rst = 1'b0;
    #1;
    chk("rst_rst_pipe", rst_pipe, 1'b1);
    chk("rst_pipe_en", pipe_en, 1'b0);
    chk("rst_tx_start", tx_start, 1'b0);
    chk("rst_tx_bus", tx_bus, 8'h00);
    chk("rst_busy", busy, 1'b1);
    step();
    step();
    rst = 1'b1;
    n = 0;
    while (rst_pipe === 1'b1 && n < 20) begin
      chk("prst_busy", busy, 1'b1);
      chk("prst_txs", tx_start, 1'b0);
      step();
      n++;
    end
    chk("prst_len", n, RST_CYC);
    chk("prst_exit_busy", busy, 1'b0);

    // Plain dump.
    snap_data = 20'hABCDE;
    log_q.delete();
    push_frame(snap_data);
    send_cmd(8'h64);
    chk("d_cap_txs", tx_start, 1'b0);
    chk("d_cap_busy", busy, 1'b1);
    step();
    chk("d_first_txs", tx_start, 1'b1);
    wait_idle(200, "d_idle");
    chk("d_left", exp_q.size(), 0);
    chk("d_len", log_q.size(), FL);
    chk("d_b0", log_q[0], 8'hA5);
    chk("d_b1", log_q[1], 8'hDE);
    chk("d_b2", log_q[2], 8'hBC);
    chk("d_b3", log_q[3], 8'h0A);
`ifdef DBG_CHECKSUM_EN
    chk("d_b4", log_q[4], 8'hCD);
`endif

    // Single step with command bytes thrown at it mid-frame.
    snap_data = 20'h1F00F;
    push_frame(snap_data);
    e0 = en_cnt;
    send_cmd(8'h73);
    chk("s_en1", pipe_en, 1'b1);
    step();
    chk("s_en0", pipe_en, 1'b0);
    chk("s_cap_txs", tx_start, 1'b0);
    step();
    chk("s_txs", tx_start, 1'b1);
    repeat (2) step();
    send_cmd(8'h72);
    step();
    send_cmd(8'h63);
    repeat (3) step();
    send_cmd(8'h73);
    wait_idle(200, "s_idle");
    chk("s_left", exp_q.size(), 0);
    chk("s_en_total", en_cnt - e0, 1);
    repeat (3) step();
    chk("s_quiet_busy", busy, 1'b0);
    chk("s_quiet_rst", rst_pipe, 1'b0);

    // Breakpoint at pc 5.
    send_cmd(8'h72);
    wait_idle(20, "r1_idle");
    chk("r1_pc", pc_r, 0);
    send_cmd(8'h62);
    chk("b_arg_busy", busy, 1'b1);
    send_cmd(8'h05);
    chk("b_done_busy", busy, 1'b0);
    snap_data = 20'h00555;
    push_frame(snap_data);
    send_cmd(8'h63);
    n = 0;
    while (pc_r != 8'd5 && n < 50) begin
      step();
      n++;
    end
    chk("bp_reach", pc_r, 5);
    chk("bp_cycles", n, 5);
    chk("bp_en0", pipe_en, 1'b0);
    wait_idle(200, "bp_idle");
    chk("bp_left", exp_q.size(), 0);
    chk("bp_pc_hold", pc_r, 5);

    // Continue from the breakpoint, then halt.
    send_cmd(8'h63);
    chk("c2_first_en", pipe_en, 1'b1);
    repeat (4) step();
    chk("c2_pc_past", pc_r >= 8'd6, 1'b1);
    chk("c2_en", pipe_en, 1'b1);
    push_frame(snap_data);
    send_cmd_en(8'h68, 1'b0, "c2_h_en");
    wait_idle(200, "c2_idle");
    chk("c2_left", exp_q.size(), 0);

    // Breakpoint match and 'h' in the same cycle: one dump only.
    send_cmd(8'h72);
    wait_idle(20, "r2_idle");
    send_cmd(8'h62);
    send_cmd(8'h03);
    snap_data = 20'h7A5C3;
    push_frame(snap_data);
    s0 = n_start;
    send_cmd(8'h63);
    repeat (3) step();
    chk("bph_pc", pc_r, 3);
    send_cmd_en(8'h68, 1'b0, "bph_en");
    wait_idle(200, "bph_idle");
    repeat (6) step();
    chk("bph_busy", busy, 1'b0);
    chk("bph_left", exp_q.size(), 0);
    chk("bph_bytes", n_start - s0, FL);

    // Free run without breakpoint, halt after 10 cycles.
    send_cmd(8'h72);
    wait_idle(20, "r3_idle");
    send_cmd(8'h6E);
    chk("n_busy", busy, 1'b0);
    snap_data = 20'h0F0F0;
    push_frame(snap_data);
    send_cmd(8'h63);
    for (int i = 0; i < 10; i++) begin
      chk("run_en", pipe_en, 1'b1);
      step();
    end
    send_cmd_en(8'h68, 1'b0, "run_h_en");
    chk("run_pc", pc_r, 10);
    wait_idle(200, "run_idle");
    chk("run_left", exp_q.size(), 0);
    chk("run_pc_hold", pc_r, 10);
    send_cmd(8'h68);
    chk("h_idle_ignored", busy, 1'b0);

    // Reset during the third byte of a frame.
    snap_data = 20'h0BEEF;
    push_frame(snap_data);
    s0 = n_start;
    send_cmd(8'h64);
    n = 0;
    while (n_start < s0 + 3 && n < 100) begin
      step();
      n++;
    end
    chk("rm_third", n_start - s0, 3);
    rst = 1'b0;
    #1;
    chk("rm_txs", tx_start, 1'b0);
    chk("rm_rst_pipe", rst_pipe, 1'b1);
    chk("rm_en", pipe_en, 1'b0);
    chk("rm_busy", busy, 1'b1);
    chk("rm_tx_bus", tx_bus, 8'h00);
    exp_q.delete();
    step();
    step();
    rst = 1'b1;
    wait_idle(20, "rm_prst_idle");
    snap_data = 20'h13579;
    push_frame(snap_data);
    l0 = log_q.size();
    send_cmd(8'h64);
    wait_idle(200, "rm_d_idle");
    chk("rm_left", exp_q.size(), 0);
    chk("rm_len", log_q.size() - l0, FL);
    chk("rm_b1", log_q[l0 + 1], 8'h79);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
